// File: rtl/line_adaptor_pkg.sv
// Shared types and constants for the cache line <-> memory burst adaptor.
// State encoding plus default beat geometry (256-bit line, 64-bit beats).
package line_adaptor_pkg;

  localparam int BEATS = 4;
  localparam int CNT_W = $clog2(BEATS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/burst_counter.sv
// Beat counter for one line burst: clear on load, step on each accepted beat.
// last flags the final beat; the wrap back to zero is the terminal condition.
module burst_counter
  import line_adaptor_pkg::*;
#(
  parameter int beats = BEATS,
  parameter int cw    = CNT_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  output logic [cw-1:0] cnt,
  output logic          last
);

  localparam logic [cw-1:0] LAST_IDX = cw'(beats - 1);

  assign last = (cnt == LAST_IDX);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= last ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/line_burst_adaptor.sv
// Performs one cache line read/write as a fixed-length burst of memory beats.
// Define LINE_ADAPTOR_ALIGN_EN to force the burst address line-aligned.
module line_burst_adaptor
  import line_adaptor_pkg::*;
#(
  parameter int s_offset = 5,
  parameter int s_line   = 256,
  parameter int s_burst  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       line_address_i,
  input  logic              line_read_i,
  input  logic              line_write_i,
  input  logic [s_line-1:0] line_wdata_i,
  output logic [s_line-1:0] line_rdata_o,
  output logic              line_resp_o,
  output logic [31:0]       burst_address_o,
  output logic              burst_read_o,
  output logic              burst_write_o,
  output logic [s_burst-1:0] burst_wdata_o,
  input  logic [s_burst-1:0] burst_rdata_i,
  input  logic              burst_resp_i
);

  localparam int beats = s_line / s_burst;
  localparam int cw    = (beats > 1) ? $clog2(beats) : 1;

  state_e state;
  logic [31:0] addr_q;
  logic [beats-1:0][s_burst-1:0] wline_q;
  logic [beats-1:0][s_burst-1:0] rline_q;
  logic [cw-1:0] cnt;
  logic last;
  logic beat_en;
  logic cnt_clr;

  assign beat_en = burst_resp_i &&
                   (state == READ || state == WRITE);
  assign cnt_clr = (state == IDLE);

  burst_counter #(
    .beats (beats),
    .cw    (cw)
  ) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .en   (beat_en),
    .cnt  (cnt),
    .last (last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      addr_q  <= '0;
      wline_q <= '0;
      rline_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (line_read_i) begin
            addr_q <= line_address_i;
            state  <= READ;
          end else if (line_write_i) begin
            addr_q  <= line_address_i;
            wline_q <= line_wdata_i;
            state   <= WRITE;
          end
        end
        READ: begin
          if (burst_resp_i) begin
            rline_q[cnt] <= burst_rdata_i;
            if (last) state <= DONE;
          end
        end
        WRITE: begin
          if (burst_resp_i && last) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign line_rdata_o  = rline_q;
  assign line_resp_o   = (state == DONE);
  assign burst_read_o  = (state == READ);
  assign burst_write_o = (state == WRITE);
  assign burst_wdata_o = (state == WRITE) ? wline_q[cnt] : '0;

`ifdef LINE_ADAPTOR_ALIGN_EN
  assign burst_address_o = {addr_q[31:s_offset], {s_offset{1'b0}}};
`else
  assign burst_address_o = addr_q;
`endif

endmodule

// File: tb/tb_line_burst_adaptor.sv
// Self-checking bench for line_burst_adaptor: vector table of whole
// transactions plus hand sequences for reset, idle responses and re-sampling.
module tb_line_burst_adaptor;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  line_address_i;
  logic         line_read_i;
  logic         line_write_i;
  logic [255:0] line_wdata_i;
  logic [255:0] line_rdata_o;
  logic         line_resp_o;
  logic [31:0]  burst_address_o;
  logic         burst_read_o;
  logic         burst_write_o;
  logic [63:0]  burst_wdata_o;
  logic [63:0]  burst_rdata_i;
  logic         burst_resp_i;

  int total = 0;
  int bad   = 0;

  logic [255:0] rq[$];
  logic [63:0]  wq[$];

  typedef struct {
    logic         rd;
    logic         wr;
    logic [31:0]  addr;
    logic [255:0] line;
    int           gap;
    logic         exp_rd;
  } vec_t;

  vec_t vt[5];

  line_burst_adaptor dut (
    .clk             (clk),
    .rst             (rst),
    .line_address_i  (line_address_i),
    .line_read_i     (line_read_i),
    .line_write_i    (line_write_i),
    .line_wdata_i    (line_wdata_i),
    .line_rdata_o    (line_rdata_o),
    .line_resp_o     (line_resp_o),
    .burst_address_o (burst_address_o),
    .burst_read_o    (burst_read_o),
    .burst_write_o   (burst_write_o),
    .burst_wdata_o   (burst_wdata_o),
    .burst_rdata_i   (burst_rdata_i),
    .burst_resp_i    (burst_resp_i)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] exp_addr(input logic [31:0] a);
`ifdef LINE_ADAPTOR_ALIGN_EN
    return {a[31:5], 5'b0};
`else
    return a;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name,
                     input logic [255:0] act,
                     input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic run_txn(input vec_t v, input logic hold_after);
    logic [63:0] beat;
    logic [63:0] wexp;
    line_read_i    = v.rd;
    line_write_i   = v.wr;
    line_address_i = v.addr;
    line_wdata_i   = v.line;
    burst_resp_i   = 1'b0;
    if (v.exp_rd) rq.push_back(v.line);
    else for (int b = 0; b < 4; b++) wq.push_back(v.line[b*64 +: 64]);
    tick();
    chk("req_rd", 256'(burst_read_o), 256'(v.exp_rd));
    chk("req_wr", 256'(burst_write_o), 256'(!v.exp_rd));
    chk("addr", 256'(burst_address_o), 256'(exp_addr(v.addr)));
    for (int b = 0; b < 4; b++) begin
      wexp = 64'h0;
      if (!v.exp_rd) begin
        if (wq.size() > 0) wexp = wq.pop_front();
        else chk("wq_empty", 256'(1), 256'(0));
      end
      for (int g = 0; g < v.gap; g++) begin
        burst_resp_i = 1'b0;
        tick();
        chk("hold_busy", 256'(burst_read_o | burst_write_o), 256'(1));
        chk("hold_noresp", 256'(line_resp_o), 256'(0));
        if (!v.exp_rd) chk("hold_wdata", 256'(burst_wdata_o), 256'(wexp));
      end
      beat = v.line[b*64 +: 64];
      burst_rdata_i = beat;
      burst_resp_i  = 1'b1;
      if (!v.exp_rd) chk("wdata", 256'(burst_wdata_o), 256'(wexp));
      tick();
    end
    burst_resp_i = 1'b0;
    chk("resp", 256'(line_resp_o), 256'(1));
    chk("done_idle", 256'(burst_read_o | burst_write_o), 256'(0));
    if (v.exp_rd) begin
      if (rq.size() > 0) chk("rdata", line_rdata_o, rq.pop_front());
      else chk("rq_empty", 256'(1), 256'(0));
    end
    if (!hold_after) begin
      line_read_i  = 1'b0;
      line_write_i = 1'b0;
    end
    tick();
    chk("resp_pulse", 256'(line_resp_o), 256'(0));
    chk("no_resample", 256'(burst_read_o | burst_write_o), 256'(0));
    line_read_i  = 1'b0;
    line_write_i = 1'b0;
    tick();
  endtask

  initial begin
    vt[0] = '{1'b1, 1'b0, 32'h0000_1234,
              {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
               64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111},
              0, 1'b1};
    vt[1] = '{1'b0, 1'b1, 32'h0000_1234,
              {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
               64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA},
              2, 1'b0};
    vt[2] = '{1'b1, 1'b1, 32'h8000_0040,
              {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
               64'h0F0F_0F0F_0F0F_0F0F, 64'hF0F0_F0F0_F0F0_F0F0},
              1, 1'b1};
    vt[3] = '{1'b0, 1'b1, 32'hFFFF_FFFF,
              {64'h5555_5555_5555_5555, 64'h6666_6666_6666_6666,
               64'h7777_7777_7777_7777, 64'h8888_8888_8888_8888},
              0, 1'b0};
    vt[4] = '{1'b1, 1'b0, 32'h0000_001F,
              {64'h1, 64'h2, 64'h3, 64'hFFFF_FFFF_FFFF_FFFF},
              3, 1'b1};

    rst            = 1'b1;
    line_address_i = '0;
    line_read_i    = 1'b0;
    line_write_i   = 1'b0;
    line_wdata_i   = '0;
    burst_rdata_i  = '0;
    burst_resp_i   = 1'b0;
    tick();
    tick();
    chk("rst_resp", 256'(line_resp_o), 256'(0));
    chk("rst_rd", 256'(burst_read_o), 256'(0));
    chk("rst_wr", 256'(burst_write_o), 256'(0));
    chk("rst_wdata", 256'(burst_wdata_o), 256'(0));
    chk("rst_addr", 256'(burst_address_o), 256'(0));
    chk("rst_rdata", line_rdata_o, 256'(0));
    rst = 1'b0;
    tick();

    for (int i = 0; i < 5; i++) run_txn(vt[i], 1'b0);

    // request held through the completion cycle must not restart at once
    run_txn(vt[0], 1'b1);

    // memory responses while idle are ignored
    burst_resp_i  = 1'b1;
    burst_rdata_i = 64'hDEAD_BEEF_DEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("idle_resp", 256'(line_resp_o), 256'(0));
      chk("idle_busy", 256'(burst_read_o | burst_write_o), 256'(0));
    end
    chk("idle_rdata", line_rdata_o, vt[0].line);
    burst_resp_i = 1'b0;
    tick();

    // reset after two beats of a read discards the partial line
    line_read_i    = 1'b1;
    line_address_i = 32'h0000_2000;
    tick();
    for (int b = 0; b < 2; b++) begin
      burst_rdata_i = 64'h9999_0000_0000_0000 | 64'(b);
      burst_resp_i  = 1'b1;
      tick();
    end
    burst_resp_i = 1'b0;
    rst          = 1'b1;
    tick();
    chk("mid_rst_rd", 256'(burst_read_o), 256'(0));
    chk("mid_rst_resp", 256'(line_resp_o), 256'(0));
    chk("mid_rst_addr", 256'(burst_address_o), 256'(0));
    chk("mid_rst_rdata", line_rdata_o, 256'(0));
    rst          = 1'b0;
    line_read_i  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("post_rst_resp", 256'(line_resp_o), 256'(0));
    end
    run_txn(vt[0], 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
